// File: rtl/phy_pkg.sv
// phy_pkg: definitions shared by the PHY transmit and receive blocks.
//   COMMA_BYTE      - alignment byte sent from reset release until first data
//   IDLE_BYTE       - filler byte sent for a lane whose valid is low
//   COMMA_COUNT_DEF - default number of aligned commas needed to lock
//   rx_state_t      - receiver alignment state encoding
//   is_payload()    - true when a received byte carries lane data
package phy_pkg;

    localparam logic [7:0] COMMA_BYTE      = 8'hBC;
    localparam logic [7:0] IDLE_BYTE       = 8'h7C;
    localparam int         COMMA_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

    function automatic logic is_payload(input logic [7:0] b,
                                        input logic [7:0] comma,
                                        input logic [7:0] idle);
        return (b != comma) && (b != idle);
    endfunction

endpackage

// File: rtl/phy_rx_s2p_if.sv
// phy_rx_s2p_if: bundle between the serial source and the receive front end.
//   serial_in            - serial bit stream, MSB first, one bit per clk_32f
//   out0..out3           - recovered lane bytes
//   valid_out0..3        - per-lane valid
//   active               - link aligned and delivering data
//   frame_strobe         - one-cycle pulse when the lane outputs update
//   state_dbg            - alignment FSM state (SEARCH/ALIGN/ACTIVE)
//
// Valid semantics: valid_outN qualifies outN and is only meaningful together
// with the lane registers it was loaded with; the receiver has no ready and
// cannot be stalled, so a consumer samples the lane bytes in the cycle where
// frame_strobe is high, and both bytes and valids hold until the next strobe.
interface phy_rx_s2p_if;

    logic       serial_in;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] out3;
    logic       valid_out0;
    logic       valid_out1;
    logic       valid_out2;
    logic       valid_out3;
    logic       active;
    logic       frame_strobe;
    logic [1:0] state_dbg;

    // Serial source side (transmitter or bench).
    modport master (
        output serial_in,
        input  out0, out1, out2, out3,
        input  valid_out0, valid_out1, valid_out2, valid_out3,
        input  active, frame_strobe, state_dbg
    );

    // Receiver side.
    modport slave (
        input  serial_in,
        output out0, out1, out2, out3,
        output valid_out0, valid_out1, valid_out2, valid_out3,
        output active, frame_strobe, state_dbg
    );

endinterface

// File: rtl/phy_rx_align.sv
// phy_rx_align: bit-to-byte alignment for the PHY receiver.
//   clk_32f   in   bit clock
//   rst       in   asynchronous active-low reset
//   serial_in in   serial data, MSB first
//   rx_byte   out  byte completed by the current edge ({sh[6:0], serial_in})
//   byte_stb  out  rx_byte is a byte-aligned data byte (ACTIVE, boundary edge)
//   active    out  alignment locked
//   state     out  FSM state, for observation
// Searches bit-by-bit for a COMMA, then requires COMMA_COUNT consecutive
// byte-aligned COMMAs before locking. Once locked it stays locked until reset.
module phy_rx_align
    import phy_pkg::*;
#(
    parameter logic [7:0] COMMA       = COMMA_BYTE,
    parameter int         COMMA_COUNT = COMMA_COUNT_DEF
) (
    input  logic      clk_32f,
    input  logic      rst,
    input  logic      serial_in,
    output logic [7:0] rx_byte,
    output logic      byte_stb,
    output logic      active,
    output rx_state_t state
);

    localparam logic [3:0] CNT_TARGET = 4'(COMMA_COUNT);

    rx_state_t  state_nxt;
    logic [7:0] sh;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_nxt;
    logic [3:0] comma_cnt;
    logic [3:0] comma_cnt_nxt;
    logic [3:0] comma_inc;

    // The byte as it will look after this edge's shift; all decisions use it
    // so that a byte is acted on at the very edge that samples its last bit.
    assign rx_byte   = {sh[6:0], serial_in};
    assign comma_inc = comma_cnt + 4'd1;
    assign active    = (state == ACTIVE);

    always_ff @(posedge clk_32f or negedge rst) begin
        if (!rst) begin
            state     <= SEARCH;
            sh        <= 8'h00;
            bit_cnt   <= 3'd0;
            comma_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            sh        <= rx_byte;
            bit_cnt   <= bit_cnt_nxt;
            comma_cnt <= comma_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        comma_cnt_nxt = comma_cnt;
        byte_stb      = 1'b0;
        case (state)
            SEARCH: begin
                // Any bit position may start a byte; bit_cnt then counts the
                // eight bits of the next byte starting from 0.
                if (rx_byte == COMMA) begin
                    state_nxt     = ALIGN;
                    comma_cnt_nxt = 4'd1;
                    bit_cnt_nxt   = 3'd0;
                end
            end
            ALIGN: begin
                bit_cnt_nxt = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (rx_byte == COMMA) begin
                        comma_cnt_nxt = comma_inc;
                        if (comma_inc == CNT_TARGET) begin
                            state_nxt = ACTIVE;
                        end
                    end else begin
                        state_nxt     = SEARCH;
                        comma_cnt_nxt = 4'd0;
                    end
                end
            end
            ACTIVE: begin
                bit_cnt_nxt = bit_cnt + 3'd1;
                byte_stb    = (bit_cnt == 3'd7);
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

endmodule

// File: rtl/phy_rx_s2p.sv
// phy_rx_s2p: receive serial-to-parallel front end of the PHY.
//   clk_32f  in   bit clock, one serial bit per rising edge
//   rst      in   asynchronous active-low reset
//   bus      slave side of phy_rx_s2p_if: serial_in in; out0..3,
//            valid_out0..3, active, frame_strobe, state_dbg out
// After alignment, bytes are dealt round-robin to lanes 0..3. Lanes 0..2 are
// buffered; the lane-3 byte goes straight to out3 and all four lanes update
// together with a one-cycle frame_strobe. IDLE and COMMA bytes become 8'h00
// with valid low.
module phy_rx_s2p
    import phy_pkg::*;
#(
    parameter logic [7:0] COMMA       = COMMA_BYTE,
    parameter logic [7:0] IDLE        = IDLE_BYTE,
    parameter int         COMMA_COUNT = COMMA_COUNT_DEF
) (
    input  logic          clk_32f,
    input  logic          rst,
    phy_rx_s2p_if.slave   bus
);

    logic [7:0] rx_byte;
    logic       byte_stb;
    logic       link_active;
    rx_state_t  align_state;

    logic       byte_ok;
    logic [7:0] byte_data;
    logic [1:0] lane_idx;
    logic [7:0] buf0, buf1, buf2;
    logic [2:0] buf_vld;
    logic [7:0] out0_q, out1_q, out2_q, out3_q;
    logic [3:0] valid_q;
    logic       strobe_q;

    phy_rx_align #(
        .COMMA       (COMMA),
        .COMMA_COUNT (COMMA_COUNT)
    ) u_align (
        .clk_32f   (clk_32f),
        .rst       (rst),
        .serial_in (bus.serial_in),
        .rx_byte   (rx_byte),
        .byte_stb  (byte_stb),
        .active    (link_active),
        .state     (align_state)
    );

    assign byte_ok   = is_payload(rx_byte, COMMA, IDLE);
    assign byte_data = byte_ok ? rx_byte : 8'h00;

    // lane_idx is 0 on entry to ACTIVE because byte_stb never fires before
    // lock, so the first byte after the last alignment COMMA lands in lane 0.
    // A COMMA while active is just an invalid byte and does not move lanes.
    always_ff @(posedge clk_32f or negedge rst) begin
        if (!rst) begin
            lane_idx <= 2'd0;
            buf0     <= 8'h00;
            buf1     <= 8'h00;
            buf2     <= 8'h00;
            buf_vld  <= 3'b000;
            out0_q   <= 8'h00;
            out1_q   <= 8'h00;
            out2_q   <= 8'h00;
            out3_q   <= 8'h00;
            valid_q  <= 4'b0000;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (byte_stb) begin
                lane_idx <= lane_idx + 2'd1;
                case (lane_idx)
                    2'd0: begin
                        buf0       <= byte_data;
                        buf_vld[0] <= byte_ok;
                    end
                    2'd1: begin
                        buf1       <= byte_data;
                        buf_vld[1] <= byte_ok;
                    end
                    2'd2: begin
                        buf2       <= byte_data;
                        buf_vld[2] <= byte_ok;
                    end
                    default: begin
                        out0_q   <= buf0;
                        out1_q   <= buf1;
                        out2_q   <= buf2;
                        out3_q   <= byte_data;
                        valid_q  <= {byte_ok, buf_vld};
                        strobe_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.out0         = out0_q;
    assign bus.out1         = out1_q;
    assign bus.out2         = out2_q;
    assign bus.out3         = out3_q;
    assign bus.valid_out0   = valid_q[0];
    assign bus.valid_out1   = valid_q[1];
    assign bus.valid_out2   = valid_q[2];
    assign bus.valid_out3   = valid_q[3];
    assign bus.active       = link_active;
    assign bus.frame_strobe = strobe_q;
    assign bus.state_dbg    = align_state;

endmodule

// File: tb/tb_phy_rx_s2p.sv
// tb_phy_rx_s2p: self-checking bench for phy_rx_s2p. Each scenario is a bit
// stream; a reference model works out from the whole stream where lock
// happens and what every frame must contain, then the stream is played in and
// the outputs are compared after every clock edge.
module tb_phy_rx_s2p;

    localparam logic [7:0] COMMA   = 8'hBC;
    localparam logic [7:0] IDLE    = 8'h7C;
    localparam int         N_COMMA = 4;

    logic clk_32f;
    logic rst;

    phy_rx_s2p_if bus ();

    phy_rx_s2p dut (
        .clk_32f (clk_32f),
        .rst     (rst),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    // ---------------- scoreboard state ----------------
    int   n_checks = 0;
    int   n_err    = 0;
    logic bit_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [35:0] pack_bus();
        return {bus.valid_out0, bus.valid_out1, bus.valid_out2, bus.valid_out3,
                bus.out0, bus.out1, bus.out2, bus.out3};
    endfunction

    // ---------------- stimulus builders ----------------
    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) bit_q.push_back(b[k]);
    endtask

    task automatic push_commas(input int n);
        for (int k = 0; k < n; k++) push_byte(COMMA);
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        push_byte(b0);
        push_byte(b1);
        push_byte(b2);
        push_byte(b3);
    endtask

    // ---------------- reference model ----------------
    // Eight-bit window ending at stream bit i (bits before the stream are 0).
    function automatic logic [7:0] win(input int i);
        logic [7:0] w;
        int         idx;
        w = 8'h00;
        for (int k = 0; k < 8; k++) begin
            idx = i - 7 + k;
            w = {w[6:0], (idx >= 0 && idx < bit_q.size()) ? bit_q[idx] : 1'b0};
        end
        return w;
    endfunction

    // Stream index at which lock is reached, or -1. A candidate COMMA may sit
    // at any bit; the following COMMAs must be exactly 8 bits apart, and a
    // failing byte restarts the search at the bit after it.
    function automatic int find_lock();
        int n;
        int start;
        int first;
        int cnt;
        int j;
        n = bit_q.size();
        start = 0;
        while (start < n) begin
            first = -1;
            for (int k = start; k < n; k++) begin
                if (win(k) == COMMA) begin
                    first = k;
                    break;
                end
            end
            if (first < 0) return -1;
            cnt = 1;
            j = first + 8;
            while (j < n && win(j) == COMMA) begin
                cnt++;
                if (cnt == N_COMMA) return j;
                j += 8;
            end
            if (j >= n) return -1;
            start = j + 1;
        end
        return -1;
    endfunction

    function automatic logic [35:0] model_frame(input int end_idx);
        logic [7:0] b;
        logic [3:0] v;
        logic [31:0] d;
        v = 4'b0000;
        d = 32'h0;
        for (int l = 0; l < 4; l++) begin
            b = win(end_idx - 32 + 8 * (l + 1));
            if (b != COMMA && b != IDLE) begin
                v[3 - l] = 1'b1;
                d[31 - 8 * l -: 8] = b;
            end
        end
        return {v, d};
    endfunction

    // ---------------- driver ----------------
    // abort_at >= 0 pulls reset mid-cycle before stream bit abort_at.
    task automatic run_scenario(input string name, input int abort_at);
        int          lock;
        logic [35:0] exp_bus;
        logic        exp_act;
        logic        exp_stb;

        @(negedge clk_32f);
        rst = 1'b0;
        bus.serial_in = 1'b0;
        #1;
        check({name, ":rst_bus"}, 64'(pack_bus()), 64'h0);
        check({name, ":rst_act"}, 64'(bus.active), 64'h0);
        check({name, ":rst_stb"}, 64'(bus.frame_strobe), 64'h0);
        check({name, ":rst_state"}, 64'(bus.state_dbg), 64'h0);
        repeat (2) @(negedge clk_32f);
        rst = 1'b1;

        lock = find_lock();
        exp_bus = '0;
        for (int i = 0; i < bit_q.size(); i++) begin
            if (i == abort_at) begin
                @(negedge clk_32f);
                #2;
                rst = 1'b0;
                #1;
                check({name, ":abort_bus"}, 64'(pack_bus()), 64'h0);
                check({name, ":abort_act"}, 64'(bus.active), 64'h0);
                check({name, ":abort_stb"}, 64'(bus.frame_strobe), 64'h0);
                return;
            end
            if (i > 0) @(negedge clk_32f);
            bus.serial_in = bit_q[i];
            @(posedge clk_32f);
            #1;
            exp_act = (lock >= 0) && (i >= lock);
            exp_stb = (lock >= 0) && (i > lock) && (((i - lock) % 32) == 0);
            if (exp_stb) exp_bus = model_frame(i);
            check({name, ":active"}, 64'(bus.active), 64'(exp_act));
            check({name, ":strobe"}, 64'(bus.frame_strobe), 64'(exp_stb));
            check({name, ":lanes"}, 64'(pack_bus()), 64'(exp_bus));
            if (i == lock) check({name, ":state_lock"}, 64'(bus.state_dbg), 64'd2);
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        rst = 1'b0;
        bus.serial_in = 1'b0;

        bit_q.delete();
        push_commas(4);
        push_frame(8'h11, 8'h22, 8'h33, 8'h44);
        push_byte(8'h00);
        run_scenario("lock", -1);

        bit_q.delete();
        bit_q.push_back(1'b1);
        bit_q.push_back(1'b0);
        bit_q.push_back(1'b1);
        push_commas(4);
        push_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        run_scenario("misalign", -1);

        bit_q.delete();
        push_commas(3);
        push_byte(8'h55);
        push_commas(4);
        push_frame(8'h01, 8'h02, 8'h03, 8'h04);
        run_scenario("broken", -1);

        bit_q.delete();
        push_commas(4);
        push_frame(8'h12, 8'h34, 8'h56, 8'h78);
        push_frame(8'h12, 8'h34, 8'h7C, 8'h56);
        run_scenario("idle", -1);

        bit_q.delete();
        push_commas(4);
        push_frame(8'h11, 8'h22, 8'h33, 8'h44);
        push_frame(8'hBC, 8'h9A, 8'hBC, 8'h7E);
        push_frame(8'h01, 8'h02, 8'h03, 8'h04);
        run_scenario("comma_act", -1);

        // Lock lands on stream bit 31; the second frame starts at bit 64,
        // so bit 77 is the 14th bit (index 13) of that frame.
        bit_q.delete();
        push_commas(4);
        push_frame(8'h11, 8'h22, 8'h33, 8'h44);
        push_frame(8'h55, 8'h66, 8'h77, 8'h88);
        run_scenario("reset_mid", 77);

        bit_q.delete();
        push_commas(3);
        push_frame(8'h11, 8'h22, 8'h33, 8'h44);
        push_frame(8'h11, 8'h22, 8'h33, 8'h44);
        run_scenario("relock_short", -1);

        bit_q.delete();
        push_commas(4);
        push_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        run_scenario("relock_full", -1);

        for (int r = 0; r < 6; r++) begin
            int nj;
            bit_q.delete();
            nj = $urandom_range(0, 7);
            for (int k = 0; k < nj; k++) bit_q.push_back(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                push_commas($urandom_range(1, 3));
                push_byte(8'($urandom_range(0, 255)));
            end
            push_commas(4);
            for (int f = 0; f < 12; f++) begin
                int sel;
                sel = $urandom_range(0, 5);
                if (sel == 0) push_byte(IDLE);
                else if (sel == 1) push_byte(COMMA);
                else push_byte(8'($urandom_range(0, 255)));
            end
            run_scenario("random", -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
